// File: rtl/sync_location_tracker.sv
// sync_location_tracker: tracks pixel (x, y, frame) from hsync/vsync with saturating
// coordinates, sticky overflow flags, line-length capture and start pulses.
module sync_location_tracker #(
  parameter int X_WIDTH     = 16,
  parameter int Y_WIDTH     = 16,
  parameter int FRAME_WIDTH = 16,
  parameter int X_MAX       = 1023,
  parameter int Y_MAX       = 1023,
  parameter int SYNC_EDGE   = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en,
  input  logic                   hsync,
  input  logic                   vsync,
  output logic [X_WIDTH-1:0]     x,
  output logic [Y_WIDTH-1:0]     y,
  output logic [FRAME_WIDTH-1:0] frame,
  output logic [X_WIDTH-1:0]     line_len,
  output logic                   line_start,
  output logic                   frame_start,
  output logic                   x_ovf,
  output logic                   y_ovf
);
  localparam logic [X_WIDTH-1:0] XM = X_WIDTH'(X_MAX);
  localparam logic [Y_WIDTH-1:0] YM = Y_WIDTH'(Y_MAX);
  logic hs_d, vs_d, hev, vev;
  // Edge history only advances on enabled cycles so held syncs across gaps count once.
  always_comb begin
    hev = (SYNC_EDGE != 0) ? (hsync & ~hs_d) : hsync;
    vev = (SYNC_EDGE != 0) ? (vsync & ~vs_d) : vsync;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x           <= '0;
      y           <= '0;
      frame       <= '0;
      line_len    <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      x_ovf       <= 1'b0;
      y_ovf       <= 1'b0;
      hs_d        <= 1'b0;
      vs_d        <= 1'b0;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      if (en) begin
        hs_d <= hsync;
        vs_d <= vsync;
        if (vev) begin
          x           <= '0;
          y           <= '0;
          frame       <= frame + 1'b1;
          x_ovf       <= 1'b0;
          y_ovf       <= 1'b0;
          frame_start <= 1'b1;
        end else if (hev) begin
          line_len   <= x;
          x          <= '0;
          line_start <= 1'b1;
          if (y < YM) y <= y + 1'b1;
          else y_ovf <= 1'b1;
        end else if (x < XM) begin
          x <= x + 1'b1;
        end else begin
          x_ovf <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_sync_location_tracker.sv
// tb_sync_location_tracker: directed scoreboard bench driving a level-mode and an
// edge-mode instance (X_MAX=7, Y_MAX=5, FRAME_WIDTH=2) with shared stimulus.
module tb_sync_location_tracker;
  typedef struct packed {
    logic        chk;
    logic [15:0] x;
    logic [15:0] y;
    logic [1:0]  f;
    logic [15:0] ll;
    logic        ls, fs, xo, yo;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic en = 1'b0, hsync = 1'b0, vsync = 1'b0;
  logic [15:0] x0, y0, ll0, x1, y1, ll1;
  logic [1:0]  f0, f1;
  logic ls0, fs0, xo0, yo0, ls1, fs1, xo1, yo1;
  exp_t q0[$], q1[$];
  int n_chk = 0, n_fail = 0, n_pop = 0;

  always #5 clk = ~clk;

  sync_location_tracker #(.X_WIDTH(16), .Y_WIDTH(16), .FRAME_WIDTH(2), .X_MAX(7), .Y_MAX(5), .SYNC_EDGE(0)) d_lvl (
    .clk(clk), .reset(reset), .en(en), .hsync(hsync), .vsync(vsync),
    .x(x0), .y(y0), .frame(f0), .line_len(ll0), .line_start(ls0), .frame_start(fs0), .x_ovf(xo0), .y_ovf(yo0));

  sync_location_tracker #(.X_WIDTH(16), .Y_WIDTH(16), .FRAME_WIDTH(2), .X_MAX(7), .Y_MAX(5), .SYNC_EDGE(1)) d_edg (
    .clk(clk), .reset(reset), .en(en), .hsync(hsync), .vsync(vsync),
    .x(x1), .y(y1), .frame(f1), .line_len(ll1), .line_start(ls1), .frame_start(fs1), .x_ovf(xo1), .y_ovf(yo1));

  function automatic exp_t mk(int x, int y, int f, int ll, int ls, int fs, int xo, int yo);
    exp_t e;
    e.chk = 1'b1;
    e.x = 16'(x);
    e.y = 16'(y);
    e.f = 2'(f);
    e.ll = 16'(ll);
    e.ls = (ls != 0);
    e.fs = (fs != 0);
    e.xo = (xo != 0);
    e.yo = (yo != 0);
    return e;
  endfunction

  task automatic step(input logic e, h, v, input exp_t a, b);
    @(negedge clk);
    en = e;
    hsync = h;
    vsync = v;
    q0.push_back(a);
    q1.push_back(b);
  endtask

  task automatic s(input logic e, h, v, input exp_t a);
    step(e, h, v, a, a);
  endtask

  task automatic cmp(input string nm, input int idx, input exp_t ex, input exp_t ac);
    n_chk++;
    if (ac !== ex) begin
      n_fail++;
      $display("FAIL %s entry %0d: got x=%0d y=%0d f=%0d ll=%0d ls=%b fs=%b xo=%b yo=%b, expected x=%0d y=%0d f=%0d ll=%0d ls=%b fs=%b xo=%b yo=%b",
               nm, idx, ac.x, ac.y, ac.f, ac.ll, ac.ls, ac.fs, ac.xo, ac.yo,
               ex.x, ex.y, ex.f, ex.ll, ex.ls, ex.fs, ex.xo, ex.yo);
    end
  endtask

  // Monitor: one scoreboard entry per clock (or asynchronous reset) event.
  initial forever begin
    exp_t a, b;
    @(posedge clk or posedge reset);
    #1;
    if (q0.size() > 0) begin
      a = q0.pop_front();
      b = q1.pop_front();
      if (a.chk) cmp("level", n_pop, a, mk(x0, y0, f0, ll0, ls0, fs0, xo0, yo0));
      if (b.chk) cmp("edge", n_pop, b, mk(x1, y1, f1, ll1, ls1, fs1, xo1, yo1));
      n_pop++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    exp_t z;
    z = mk(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, z, z);
    @(negedge clk) reset = 1'b0;
    for (int i = 1; i <= 5; i++) s(1, 0, 0, mk(i, 0, 0, 0, 0, 0, 0, 0));
    s(1, 1, 0, mk(0, 1, 0, 5, 1, 0, 0, 0));
    s(1, 0, 0, mk(1, 1, 0, 5, 0, 0, 0, 0));
    s(1, 0, 0, mk(2, 1, 0, 5, 0, 0, 0, 0));
    s(0, 1, 0, mk(2, 1, 0, 5, 0, 0, 0, 0));
    s(0, 0, 0, mk(2, 1, 0, 5, 0, 0, 0, 0));
    for (int k = 1; k <= 8; k++) s(1, 0, 0, mk((k + 2 > 7) ? 7 : k + 2, 1, 0, 5, 0, 0, 0, 0) | exp_t'(k >= 6 ? 2 : 0));
    s(1, 0, 1, mk(0, 0, 1, 5, 0, 1, 0, 0));
    s(1, 0, 0, mk(1, 0, 1, 5, 0, 0, 0, 0));
    s(1, 0, 0, mk(2, 0, 1, 5, 0, 0, 0, 0));
    s(1, 1, 0, mk(0, 1, 1, 2, 1, 0, 0, 0));
    s(1, 0, 0, mk(1, 1, 1, 2, 0, 0, 0, 0));
    s(1, 1, 0, mk(0, 2, 1, 1, 1, 0, 0, 0));
    s(1, 0, 0, mk(1, 2, 1, 1, 0, 0, 0, 0));
    s(1, 1, 0, mk(0, 3, 1, 1, 1, 0, 0, 0));
    s(1, 0, 0, mk(1, 3, 1, 1, 0, 0, 0, 0));
    s(1, 1, 1, mk(0, 0, 2, 1, 0, 1, 0, 0));
    for (int i = 1; i <= 6; i++) begin
      s(1, 0, 0, mk(1, i - 1, 2, 1, 0, 0, 0, 0));
      s(1, 1, 0, mk(0, (i > 5) ? 5 : i, 2, 1, 1, 0, 0, (i == 6) ? 1 : 0));
    end
    s(1, 0, 1, mk(0, 0, 3, 1, 0, 1, 0, 0));
    s(1, 0, 0, mk(1, 0, 3, 1, 0, 0, 0, 0));
    s(1, 0, 1, mk(0, 0, 0, 1, 0, 1, 0, 0));
    s(1, 0, 0, mk(1, 0, 0, 1, 0, 0, 0, 0));
    for (int i = 1; i <= 4; i++)
      step(1, 1, 0, mk(0, i, 0, (i == 1) ? 1 : 0, 1, 0, 0, 0), mk(i - 1, 1, 0, 1, (i == 1) ? 1 : 0, 0, 0, 0));
    step(1, 0, 0, mk(1, 4, 0, 0, 0, 0, 0, 0), mk(4, 1, 0, 1, 0, 0, 0, 0));
    step(1, 0, 1, mk(0, 0, 1, 0, 0, 1, 0, 0), mk(0, 0, 1, 1, 0, 1, 0, 0));
    s(1, 1, 0, mk(0, 1, 1, 0, 1, 0, 0, 0));
    s(1, 0, 0, mk(1, 1, 1, 0, 0, 0, 0, 0));
    s(1, 1, 0, mk(0, 2, 1, 1, 1, 0, 0, 0));
    for (int i = 1; i <= 4; i++) s(1, 0, 0, mk(i, 2, 1, 1, 0, 0, 0, 0));
    @(posedge clk);
    #3;
    q0.push_back(z);
    q1.push_back(z);
    en = 1'b0;
    reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    s(1, 0, 0, mk(1, 0, 0, 0, 0, 0, 0, 0));
    s(1, 1, 0, mk(0, 1, 0, 1, 1, 0, 0, 0));
    s(0, 0, 0, mk(0, 1, 0, 1, 0, 0, 0, 0));
    repeat (3) @(posedge clk);
    #2;
    n_chk++;
    if (q0.size() != 0 || q1.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d/%0d pending entries, expected 0/0", q0.size(), q1.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
